tx_frame_arbiter: RTL and testbench

//  Shares the single Ethernet TX MAC byte path between two frame sources (bridge port

---
 rtl/tx_frame_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter
//  Shares one MAC TX byte path between two frame sources, one whole frame at a
//  time, with round-robin grant. It zero-pads runts to MIN_LEN, forces an
//  inter-frame gap after each sent frame, and drains frames of illegal length
//  without sending them.
module tx_frame_arbiter #(
  parameter int DATA_W     = 8,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514,
  parameter int IFG_CYCLES = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [15:0]       len0,
  input  logic [15:0]       len1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              next0,
  output logic              next1,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  output logic              tx_last_o,
  input  logic              tx_mac_ready,
  output logic [1:0]        grant_o,
  output logic              drop_o,
  output logic              busy_o
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  localparam logic [15:0] IFG_L = 16'(IFG_CYCLES);

  typedef enum logic [2:0] {IDLE, SEND, PAD, IFG, DROP} state_t;

  state_t            state;
  logic              sel;       // source that owns the current frame
  logic              rr_last;   // source served most recently
  logic [15:0]       len_q;     // latched length of the current frame
  logic [15:0]       total_q;   // bytes to put on the wire (len padded to MIN_LEN)
  logic [15:0]       cnt;       // bytes loaded so far (SEND/PAD) or pops issued (DROP)
  logic [15:0]       ifg_cnt;

  logic              any_req;
  logic              pick;
  logic [15:0]       pick_len;
  logic [15:0]       pick_total;
  logic              pick_legal;
  logic [DATA_W-1:0] pick_data;
  logic [DATA_W-1:0] cur_data;
  logic [15:0]       drop_n;
  logic              xfer;
  logic              pop;
  logic              pop_src;

  // Arbitration and source selection for the frame that would start this cycle
  always_comb begin
    any_req    = req0 | req1;
    pick       = (req0 & req1) ? ~rr_last : req1;
    pick_len   = pick ? len1 : len0;
    pick_total = (pick_len < MIN_L) ? MIN_L : pick_len;
    pick_legal = (pick_len != 16'd0) && (pick_len <= MAX_L);
    pick_data  = pick ? data1 : data0;
    cur_data   = sel ? data1 : data0;
    drop_n     = (len_q == 16'd0) ? 16'd1 : len_q;
    xfer       = tx_valid_o & tx_mac_ready;
  end

  // Pop strobe is combinational so a first-word-fall-through source presents
  // the following byte in time for back-to-back transfers; gated by reset so an
  // aborted frame never consumes source data
  always_comb begin
    pop     = 1'b0;
    pop_src = sel;
    if (rst) begin
      case (state)
        IDLE: begin
          pop     = any_req & pick_legal;
          pop_src = pick;
        end
        SEND:    pop = xfer && (cnt < len_q);
        DROP:    pop = 1'b1;
        default: pop = 1'b0;
      endcase
    end
    next0 = pop & ~pop_src;
    next1 = pop & pop_src;
  end

  assign busy_o = (state != IDLE);

  // Frame state machine with registered MAC-side outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      rr_last    <= 1'b1;
      len_q      <= 16'd0;
      total_q    <= 16'd0;
      cnt        <= 16'd0;
      ifg_cnt    <= 16'd0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      tx_last_o  <= 1'b0;
      grant_o    <= 2'b00;
      drop_o     <= 1'b0;
    end else begin
      drop_o <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel     <= pick;
            rr_last <= pick;
            len_q   <= pick_len;
            total_q <= pick_total;
            grant_o <= pick ? 2'b10 : 2'b01;
            if (pick_legal) begin
              tx_data_o  <= pick_data;
              tx_valid_o <= 1'b1;
              tx_last_o  <= (pick_total == 16'd1);
              cnt        <= 16'd1;
              state      <= SEND;
            end else begin
              drop_o <= 1'b1;
              cnt    <= 16'd0;
              state  <= DROP;
            end
          end
        end

        SEND: begin
          if (xfer) begin
            if (cnt == total_q) begin
              tx_data_o  <= '0;
              tx_valid_o <= 1'b0;
              tx_last_o  <= 1'b0;
              grant_o    <= 2'b00;
              ifg_cnt    <= 16'd0;
              state      <= IFG;
            end else if (cnt < len_q) begin
              tx_data_o <= cur_data;
              tx_last_o <= ((cnt + 16'd1) == total_q);
              cnt       <= cnt + 16'd1;
            end else begin
              // source exhausted but frame still short of MIN_LEN
              tx_data_o <= '0;
              tx_last_o <= ((cnt + 16'd1) == total_q);
              cnt       <= cnt + 16'd1;
              state     <= PAD;
            end
          end
        end

        PAD: begin
          if (xfer) begin
            if (cnt == total_q) begin
              tx_data_o  <= '0;
              tx_valid_o <= 1'b0;
              tx_last_o  <= 1'b0;
              grant_o    <= 2'b00;
              ifg_cnt    <= 16'd0;
              state      <= IFG;
            end else begin
              tx_data_o <= '0;
              tx_last_o <= ((cnt + 16'd1) == total_q);
              cnt       <= cnt + 16'd1;
            end
          end
        end

        IFG: begin
          // a zero-length gap still spends this one clock before IDLE
          if ((ifg_cnt + 16'd1) >= IFG_L) begin
            state <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 16'd1;
          end
        end

        DROP: begin
          // one pop per clock; a zero-length descriptor still needs one pop
          if (({1'b0, cnt} + 17'd1) >= {1'b0, drop_n}) begin
            grant_o <= 2'b00;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          tx_valid_o <= 1'b0;
          grant_o    <= 2'b00;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: FWFT source models, frame-level reference model,
// directed steps plus randomized frames and MAC backpressure.
module tb_tx_frame_arbiter;

  localparam int MIN_LEN    = 60;
  localparam int MAX_LEN    = 1514;
  localparam int IFG_CYCLES = 12;
  localparam int MEM        = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] len0, len1;
  logic [7:0]  data0, data1;
  logic        next0, next1;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o, tx_last_o, tx_mac_ready;
  logic [1:0]  grant_o;
  logic        drop_o, busy_o;

  tx_frame_arbiter #(
    .DATA_W(8), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .IFG_CYCLES(IFG_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1), .next0(next0), .next1(next1),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_last_o(tx_last_o),
    .tx_mac_ready(tx_mac_ready), .grant_o(grant_o), .drop_o(drop_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // source buffers: byte streams plus queues of pending frame lengths
  logic [7:0] mem0 [MEM];
  logic [7:0] mem1 [MEM];
  int idx0 = 0, idx1 = 0;   // bytes popped from each source
  int hp0 = 0, hp1 = 0;     // pops taken from the head frame
  int q0[$], q1[$];
  int m_last = 1;           // model: source served last
  int ready_mode = 0;       // 0: held high, 1: toggling, 2: random

  // observations
  logic [10:0] got[$];
  logic [10:0] expq[$];
  int gaps[$];
  int gap = 0;
  bit in_gap = 0;
  int pops0, pops1, drops, vcyc, inv_err;
  int exp_pops0, exp_pops1, exp_drops;
  bit prev_stall = 0;
  logic [8:0] prev_out;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int need(int l);
    return (l == 0) ? 1 : l;
  endfunction

  task automatic drive_src();
    req0 = (q0.size() > 0);
    len0 = 16'd0;
    if (req0) len0 = 16'(q0[0]);
    data0 = mem0[idx0 % MEM];
    req1 = (q1.size() > 0);
    len1 = 16'd0;
    if (req1) len1 = 16'(q1[0]);
    data1 = mem1[idx1 % MEM];
  endtask

  // one clock: observe at negedge, then apply pops and new inputs after posedge
  task automatic tick();
    bit p0, p1;
    @(negedge clk);
    p0 = next0;
    p1 = next1;
    if (rst) begin
      if (in_gap) begin
        if (tx_valid_o) begin
          gaps.push_back(gap);
          in_gap = 0;
        end else begin
          gap++;
        end
      end
      if (prev_stall)
        check("stall_hold", {tx_valid_o, tx_last_o, tx_data_o}, {1'b1, prev_out});
      prev_stall = tx_valid_o && !tx_mac_ready;
      prev_out   = {tx_last_o, tx_data_o};
      if (tx_valid_o && tx_mac_ready) begin
        got.push_back({grant_o, tx_last_o, tx_data_o});
        if (tx_last_o) begin
          in_gap = 1;
          gap    = 0;
        end
      end
      if (next0 && next1) inv_err++;
      if (next0 && grant_o == 2'b10) inv_err++;
      if (next1 && grant_o == 2'b01) inv_err++;
      pops0 += int'(p0);
      pops1 += int'(p1);
      if (drop_o) drops++;
      if (tx_valid_o) vcyc++;
    end else begin
      prev_stall = 0;
    end
    @(posedge clk);
    #1;
    if (p0) begin
      idx0++; hp0++;
      if (q0.size() > 0 && hp0 >= need(q0[0])) begin void'(q0.pop_front()); hp0 = 0; end
    end
    if (p1) begin
      idx1++; hp1++;
      if (q1.size() > 0 && hp1 >= need(q1[0])) begin void'(q1.pop_front()); hp1 = 0; end
    end
    case (ready_mode)
      0:       tx_mac_ready = 1'b1;
      1:       tx_mac_ready = ~tx_mac_ready;
      default: tx_mac_ready = ($urandom_range(0, 3) != 0);
    endcase
    drive_src();
  endtask

  // frame-level reference: arbitration order, wire bytes, pops and drops
  task automatic build_expect();
    int a[$], b[$];
    int pa, pb, s, l, tot;
    a = q0; b = q1; pa = idx0; pb = idx1;
    expq.delete();
    exp_pops0 = 0; exp_pops1 = 0; exp_drops = 0;
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) s = 1 - m_last;
      else s = (a.size() > 0) ? 0 : 1;
      m_last = s;
      l = s ? b.pop_front() : a.pop_front();
      if (l == 0 || l > MAX_LEN) begin
        exp_drops++;
        if (s) begin exp_pops1 += need(l); pb += need(l); end
        else   begin exp_pops0 += need(l); pa += need(l); end
      end else begin
        tot = (l < MIN_LEN) ? MIN_LEN : l;
        for (int k = 0; k < tot; k++) begin
          logic [7:0] d;
          d = 8'h00;
          if (k < l) d = s ? mem1[(pb + k) % MEM] : mem0[(pa + k) % MEM];
          expq.push_back({(s ? 2'b10 : 2'b01), (k == tot - 1), d});
        end
        if (s) begin exp_pops1 += l; pb += l; end
        else   begin exp_pops0 += l; pa += l; end
      end
    end
  endtask

  task automatic run_step(string name, int budget);
    int c, n;
    got.delete(); gaps.delete();
    pops0 = 0; pops1 = 0; drops = 0; vcyc = 0; inv_err = 0; in_gap = 0; gap = 0;
    build_expect();
    drive_src();
    for (c = 0; c < budget; c++) begin
      tick();
      if (q0.size() == 0 && q1.size() == 0 && !busy_o) break;
    end
    check({name, "_done_in_budget"}, c < budget, 1);
    check({name, "_n_xfer"}, got.size(), expq.size());
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++) check({name, "_byte"}, got[i], expq[i]);
    check({name, "_pops0"}, pops0, exp_pops0);
    check({name, "_pops1"}, pops1, exp_pops1);
    check({name, "_drops"}, drops, exp_drops);
    check({name, "_next_rules"}, inv_err, 0);
  endtask

  task automatic check_idle_outputs(string name);
    check({name, "_data"},  tx_data_o, 0);
    check({name, "_valid"}, tx_valid_o, 0);
    check({name, "_last"},  tx_last_o, 0);
    check({name, "_next0"}, next0, 0);
    check({name, "_next1"}, next1, 0);
    check({name, "_grant"}, grant_o, 0);
    check({name, "_drop"},  drop_o, 0);
    check({name, "_busy"},  busy_o, 0);
  endtask

  initial begin
    int c, l;
    logic [10:0] first;
    for (int i = 0; i < MEM; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    rst = 1'b0;
    tx_mac_ready = 1'b1;
    drive_src();

    // reset state
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // single 64-byte frame from source 0, then the gap
    ready_mode = 0;
    q0.push_back(64);
    run_step("t1", 400);
    check("t1_ifg_len", gap, IFG_CYCLES);
    check("t1_vcyc", vcyc, 64);

    // runt from source 1 padded to MIN_LEN
    q1.push_back(10);
    run_step("t2", 400);

    // both sources, alternating grants with a gap between frames
    q0.push_back(64); q0.push_back(64);
    q1.push_back(64); q1.push_back(64);
    run_step("t3", 2000);
    check("t3_n_gaps", gaps.size(), 3);
    for (int i = 0; i < gaps.size(); i++) check("t3_gap", gaps[i], IFG_CYCLES + 1);

    // MAC backpressure toggling every clock
    ready_mode = 1;
    q0.push_back(64);
    run_step("t4", 800);
    ready_mode = 0;
    tx_mac_ready = 1'b1;

    // illegal lengths: oversize and zero
    q0.push_back(1600);
    q0.push_back(0);
    run_step("t5", 4000);
    check("t5_valid_cycles", vcyc, 0);

    // randomized frames on both sources with random backpressure
    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      case ($urandom_range(0, 9))
        0:       l = 0;
        1:       l = $urandom_range(MAX_LEN + 1, MAX_LEN + 30);
        2:       l = 1;
        3:       l = $urandom_range(MIN_LEN - 1, MIN_LEN + 1);
        default: l = $urandom_range(1, 120);
      endcase
      if (r % 2 == 0) q0.push_back(l); else q1.push_back(l);
    end
    q0.push_back(MAX_LEN);
    run_step("rand", 20000);
    ready_mode = 0;
    tx_mac_ready = 1'b1;

    // reset in the middle of a source-0 frame
    got.delete();
    q0.push_back(64);
    drive_src();
    for (c = 0; c < 400; c++) begin
      tick();
      if (got.size() >= 20) break;
    end
    check("rst_mid_reached", got.size(), 20);
    rst = 1'b0;
    tick();
    check_idle_outputs("rst_mid");
    // the environment discards its own partial frame
    q0.delete(); hp0 = 0;
    q0.push_back(64);
    q1.push_back(64);
    drive_src();
    tick();
    check("rst_hold_next0", next0, 0);
    check("rst_hold_next1", next1, 0);
    rst = 1'b1;
    m_last = 1;
    run_step("rst_rr", 2000);
    first = 11'd0;
    if (got.size() > 0) first = got[0];
    check("rst_rr_first_grant", first[10:9], 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
